adc_stream_parser: RTL

ADC_STREAM_PARSER -- requirements
Module: adc_stream_parser

---
 rtl/adc_stream_pkg.sv | 20 ++
 rtl/adc_axis_out_reg.sv | 32 +++
 rtl/adc_stream_parser.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/adc_stream_pkg.sv
// adc_stream_pkg: shared tag codes, parser states and field widths for the ADC stream parser.
package adc_stream_pkg;
    localparam int TS_W     = 30;
    localparam int SAMPLE_W = 15;

    localparam logic [1:0] TAG_TS_HI = 2'b00;
    localparam logic [1:0] TAG_TS_LO = 2'b01;
    localparam logic [1:0] TAG_DATA  = 2'b10;
    localparam logic [1:0] TAG_LAST  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TS_HI  = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    function automatic logic [15:0] sext(input logic [SAMPLE_W-1:0] x);
        return {x[SAMPLE_W-1], x};
    endfunction
endpackage

// File: rtl/adc_axis_out_reg.sv
// adc_axis_out_reg: single-slot AXI-stream output register; holds data/last while stalled.
module adc_axis_out_reg
    import adc_stream_pkg::*;
(
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                load,
    input  logic                last_in,
    input  logic [SAMPLE_W-1:0] a,
    input  logic [SAMPLE_W-1:0] b,
    output logic                ready,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [31:0]         m_axis_tdata,
    output logic                m_axis_tlast
);
    assign ready = !m_axis_tvalid || m_axis_tready;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (ready) begin
            m_axis_tvalid <= load;
            if (load) begin
                m_axis_tdata <= {sext(b), sext(a)};
                m_axis_tlast <= last_in;
            end
        end
    end
endmodule

// File: rtl/adc_stream_parser.sv
// adc_stream_parser: decodes tagged ADC words into sign-extended samples with series tracking.
// Statistics counters and clear_stats are active only when ADC_PARSER_STATS_EN is defined.
module adc_stream_parser
    import adc_stream_pkg::*;
#(
    parameter int MAX_SAMPLES = 65536,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic [31:0]          s_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic [2*TS_W-1:0]    series_ts,
    output logic [31:0]          series_len,
    output logic                 series_done,
    output logic [CNT_WIDTH-1:0] series_count,
    output logic [CNT_WIDTH-1:0] sample_count,
    output logic [CNT_WIDTH-1:0] error_count,
    input  logic                 clear_stats
);
    logic [1:0]      tag;
    logic            fire;
    state_t          state, state_nx;
    logic [31:0]     len, len_nx, done_len;
    logic [TS_W-1:0] ts_lo;
    logic            emit, last, err, done, ts_lo_ld, ts_hi_ld, as_idle;

    assign tag  = s_axis_tdata[31:30];
    assign fire = s_axis_tvalid && s_axis_tready;

    // A word raises at most one error even when it both aborts a series and is illegal from IDLE.
    always_comb begin
        state_nx = state;
        len_nx   = len;
        done_len = len;
        emit     = 1'b0;
        last     = 1'b0;
        err      = 1'b0;
        done     = 1'b0;
        ts_lo_ld = 1'b0;
        ts_hi_ld = 1'b0;
        as_idle  = 1'b0;
        case (state)
            ST_TS_HI: begin
                if (tag == TAG_TS_HI) begin
                    ts_hi_ld = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    err     = 1'b1;
                    as_idle = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (tag[1]) begin
                    emit   = 1'b1;
                    len_nx = len + 32'd1;
                    if (tag == TAG_LAST || len == 32'(MAX_SAMPLES)) begin
                        last     = 1'b1;
                        done     = 1'b1;
                        done_len = len + 32'd1;
                        err      = (len == 32'(MAX_SAMPLES));
                        len_nx   = '0;
                        state_nx = ST_IDLE;
                    end
                end else begin
                    err     = 1'b1;
                    done    = 1'b1;
                    len_nx  = '0;
                    as_idle = 1'b1;
                end
            end
            default: as_idle = 1'b1;
        endcase
        if (as_idle) begin
            state_nx = ST_IDLE;
            case (tag)
                TAG_TS_LO: begin
                    ts_lo_ld = 1'b1;
                    state_nx = ST_TS_HI;
                end
                TAG_DATA: begin
                    emit     = 1'b1;
                    len_nx   = 32'd1;
                    state_nx = ST_ACTIVE;
                end
                TAG_LAST: begin
                    emit     = 1'b1;
                    last     = 1'b1;
                    done     = 1'b1;
                    done_len = 32'd1;
                end
                default: err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state       <= ST_IDLE;
            len         <= '0;
            ts_lo       <= '0;
            series_ts   <= '0;
            series_len  <= '0;
            series_done <= 1'b0;
        end else begin
            series_done <= fire && done;
            if (fire) begin
                state <= state_nx;
                len   <= len_nx;
                if (ts_lo_ld)
                    ts_lo <= s_axis_tdata[TS_W-1:0];
                if (ts_hi_ld)
                    series_ts <= {s_axis_tdata[TS_W-1:0], ts_lo};
                if (done)
                    series_len <= done_len;
            end
        end
    end

    adc_axis_out_reg u_out (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .load          (fire && emit),
        .last_in       (last),
        .a             (s_axis_tdata[29:15]),
        .b             (s_axis_tdata[14:0]),
        .ready         (s_axis_tready),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast)
    );

`ifdef ADC_PARSER_STATS_EN
    logic [CNT_WIDTH-1:0] s_cnt, m_cnt, e_cnt;

    always_ff @(posedge aclk) begin
        if (!aresetn || clear_stats) begin
            s_cnt <= '0;
            m_cnt <= '0;
            e_cnt <= '0;
        end else if (fire) begin
            if (done && !(&s_cnt))
                s_cnt <= s_cnt + CNT_WIDTH'(1);
            if (emit && !(&m_cnt))
                m_cnt <= m_cnt + CNT_WIDTH'(1);
            if (err && !(&e_cnt))
                e_cnt <= e_cnt + CNT_WIDTH'(1);
        end
    end

    assign series_count = s_cnt;
    assign sample_count = m_cnt;
    assign error_count  = e_cnt;
`else
    logic unused_clear;
    assign unused_clear = clear_stats;
    assign series_count = '0;
    assign sample_count = '0;
    assign error_count  = '0;
`endif
endmodule
